uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver, the receive half of the monitor FPGA's UART link alongside the transmitter. It samples the asynchronous `rx` line on the oversampled baud clock and detects and validates the start bit. It shifts in `NUM_DATA_BITS` data bits LSB-first, checks optional parity and the stop bit, then presents the byte with a one-cycle `done` pulse and error flags to the host-side logic.

## Interface
- `NUM_DATA_BITS`, 8 (`` `NUM_DATA_BITS `` from `uart_globals.svh`): data bits per frame.
- `OVERSAMPLE`, 16: `baud` cycles per bit period; even, ≥ 4.
- `PARITY_EN`, 1: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd.
- `baud`  in  1: oversampled baud clock, OVERSAMPLE × bit rate; the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: receiver enable. Low means the receiver is held idle.
- `rx`  in  1: asynchronous serial line, idle high.
- `data`  out  NUM_DATA_BITS: last received byte. Valid from `done` until the next `done`.
- `done`  out  1: one-cycle pulse marking the end of a frame.
- `busy`  out  1: a frame is in progress.
- `error`  out  1: `parity_err | framing_err`, valid with `done`.
- `parity_err`  out  1: parity mismatch in the last frame.
- `framing_err`  out  1: stop bit was sampled low in the last frame.

## Operation
- Reset values: `data`=0, `done`=0, `busy`=0, `error`=0, `parity_err`=0, `framing_err`=0, state=IDLE, counters=0, synchronizer flops=1.
- `rx` passes through a 2-flop synchronizer preset to 1. All decisions use the synchronized value `rx_s`.
- IDLE: on `rx_s` falling (prev 1, now 0) with `enable` high, load tick counter=0, set `busy`, go to START_BIT.
- START_BIT: at tick OVERSAMPLE/2−1, sample `rx_s`.
  - If 1, it is a false start: go to IDLE, clear `busy`, no `done`.
  - If 0, reset the tick counter and go to DATA_BITS.
- DATA_BITS: every OVERSAMPLE ticks (the mid-bit point), shift `rx_s` into shift register bit `bit_idx`, LSB first.
  - After bit NUM_DATA_BITS−1, go to PARITY_BIT if PARITY_EN, else STOP_BIT.
- PARITY_BIT: sample at mid-bit.
  - `parity_err` = sampled bit ≠ (^shift XOR PARITY_ODD).
- STOP_BIT: sample at mid-bit and set `framing_err` = !sample.
  - Next cycle: copy shift register to `data`, pulse `done`, update `error`, clear `busy`, go to IDLE.
- `data` and the error flags update only at `done`. A received frame with errors still updates `data`.
- `enable` low in any state acts synchronously on the next edge: state=IDLE, `busy`=0, `done`=0, counters cleared. `data` and the flags are held.
- A frame in progress when `enable` drops is discarded.
- `rst_n` asserted mid-frame: all outputs take their reset values immediately.
- After `rst_n` deasserts, a line held low does not produce a start. A falling edge is required.
- Back-to-back frames: a new falling edge is accepted from the cycle after `done`. Stop-bit length beyond the half bit is not checked.

## Timing
- Synchronizer latency: 2 `baud` cycles.
- Start bit is sampled OVERSAMPLE/2 cycles after the detected edge. Each later sample is OVERSAMPLE cycles after the previous one.
- `done` asserts 1 cycle after the stop-bit sample. That is 2 + OVERSAMPLE/2 + (NUM_DATA_BITS + PARITY_EN + 1)·OVERSAMPLE + 1 cycles after the `rx` falling edge, ±1 for the synchronizer phase.
- `done` is exactly 1 cycle wide. `busy` falls in the same cycle `done` rises.
- Counter widths: tick counter $clog2(OVERSAMPLE) bits; `bit_idx` $clog2(NUM_DATA_BITS)+1 bits.
- No wrap-around beyond the terminal counts.

## Structure
- Add to `uart_globals.svh`:
  - `` `STATE_START_BIT ``, alongside the existing `` `STATE_IDLE ``, `` `STATE_DATA_BITS ``, `` `STATE_PARITY_BIT ``, `` `STATE_STOP_BIT ``.
  - `` `OVERSAMPLE `` default.
- The state encoding is shared with the transmitter.
- One sub-module: `uart_rx_sync`, the 2-flop synchronizer with set-on-reset plus falling-edge detect. Outputs `rx_s` and `rx_fall`.
- All else lives in `uart_rx`: FSM, tick counter, bit counter, shift register, parity accumulator.

## Test plan
- Bench settings: OVERSAMPLE=16, 8N1 then 8E1. Bits are driven LSB first.
- Reset: `rst_n`=0 with `rx`=1. All outputs are 0. Release reset, drive nothing, and `done` stays 0 for 500 cycles.
- 8E1 frame 0xA5: data bits 1,0,1,0,0,1,0,1, parity 0, stop 1 → single `done` pulse, `data`=0xA5, `error`=0, `busy` high for the whole frame.
- Same frame with parity forced to 1 → `data`=0xA5, `parity_err`=1, `error`=1. Stop forced to 0 → `framing_err`=1.
- Glitch: `rx` low for 4 cycles then high → no `done`, `busy` returns to 0 within 9 cycles.
- Back-to-back 8N1 frames 0x00 then 0xFF with no idle gap → two `done` pulses, `data`=0x00 then 0xFF, no errors.
- `enable` dropped after the 3rd data bit of 0x3C → `busy`=0 next cycle, no `done`, `data` unchanged. Re-enable and send 0x3C again → `data`=0x3C.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and types for the UART receiver.
// The state encoding is common to the UART transmitter and receiver.
package uart_rx_pkg;

    localparam int unsigned NUM_DATA_BITS_DEF = 8;
    localparam int unsigned OVERSAMPLE_DEF    = 16;
    localparam int unsigned STATE_W           = 3;

    localparam logic [STATE_W-1:0] STATE_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] STATE_START_BIT  = 3'd1;
    localparam logic [STATE_W-1:0] STATE_DATA_BITS  = 3'd2;
    localparam logic [STATE_W-1:0] STATE_PARITY_BIT = 3'd3;
    localparam logic [STATE_W-1:0] STATE_STOP_BIT   = 3'd4;

    typedef struct packed {
        logic parity_err;
        logic framing_err;
    } rx_flags_t;

    // Expected parity bit given the XOR of the data bits and the odd/even select.
    function automatic logic parity_expected(input logic data_xor, input logic odd);
        return data_xor ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line (set on reset) plus falling-edge detect.
// Edges are only reported once both compared samples come from the real line.
module uart_rx_sync (
    input  logic baud,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic       meta;
    logic       sync;
    logic       prev;
    logic [1:0] warm;

    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
            warm <= 2'd0;
        end else begin
            meta <= rx;
            sync <= meta;
            prev <= sync;
            if (warm != 2'd3) begin
                warm <= warm + 2'd1;
            end
        end
    end

    // The preset ones must flush out first, so a line held low across reset is no edge.
    assign rx_s    = sync;
    assign rx_fall = prev & ~sync & (warm == 2'd3);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit validation, LSB-first data, optional
// parity and stop-bit check, with a one-cycle done pulse and held error flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned NUM_DATA_BITS = NUM_DATA_BITS_DEF,
    parameter int unsigned OVERSAMPLE    = OVERSAMPLE_DEF,
    parameter int unsigned PARITY_EN     = 1,
    parameter int unsigned PARITY_ODD    = 0
) (
    input  logic                     baud,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     rx,
    output logic [NUM_DATA_BITS-1:0] data,
    output logic                     done,
    output logic                     busy,
    output logic                     error,
    output logic                     parity_err,
    output logic                     framing_err
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(NUM_DATA_BITS) + 1;

    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NUM_DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    logic [STATE_W-1:0]       state_q,   state_d;
    logic [TICK_W-1:0]        tick_q,    tick_d;
    logic [TICK_W-1:0]        tick_inc;
    logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
    logic [NUM_DATA_BITS-1:0] shift_q,   shift_d;
    logic                     par_acc_q, par_acc_d;
    logic                     par_bad_q, par_bad_d;
    logic                     stop_bad_q, stop_bad_d;
    logic                     finish_q,  finish_d;
    logic [NUM_DATA_BITS-1:0] data_q,    data_d;
    logic                     done_q,    done_d;
    logic                     busy_q,    busy_d;
    logic                     error_q,   error_d;
    rx_flags_t                flags_q,   flags_d;

    uart_rx_sync u_sync (
        .baud    (baud),
        .rst_n   (rst_n),
        .rx      (rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    // State and datapath registers.
    always_ff @(posedge baud or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stop_bad_q <= 1'b0;
            finish_q   <= 1'b0;
            data_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_bad_q  <= par_bad_d;
            stop_bad_q <= stop_bad_d;
            finish_q   <= finish_d;
            data_q     <= data_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            flags_q    <= flags_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_bad_d  = par_bad_q;
        stop_bad_d = stop_bad_q;
        finish_d   = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        error_d    = error_q;
        flags_d    = flags_q;
        tick_inc   = tick_q + TICK_W'(1);

        if (!enable) begin
            state_d   = STATE_IDLE;
            tick_d    = '0;
            bit_idx_d = '0;
            busy_d    = 1'b0;
        end else if (finish_q) begin
            // Cycle after the stop sample: publish the frame, even if it has errors.
            data_d              = shift_q;
            done_d              = 1'b1;
            busy_d              = 1'b0;
            flags_d.parity_err  = par_bad_q;
            flags_d.framing_err = stop_bad_q;
            error_d             = par_bad_q | stop_bad_q;
            state_d             = STATE_IDLE;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (rx_fall) begin
                        tick_d     = '0;
                        bit_idx_d  = '0;
                        par_acc_d  = 1'b0;
                        par_bad_d  = 1'b0;
                        stop_bad_d = 1'b0;
                        busy_d     = 1'b1;
                        state_d    = STATE_START_BIT;
                    end
                end
                STATE_START_BIT: begin
                    if (tick_q == HALF_TICK) begin
                        tick_d = '0;
                        if (rx_s) begin
                            busy_d  = 1'b0;
                            state_d = STATE_IDLE;
                        end else begin
                            state_d = STATE_DATA_BITS;
                        end
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                STATE_DATA_BITS: begin
                    if (tick_q == FULL_TICK) begin
                        tick_d    = '0;
                        shift_d   = {rx_s, shift_q[NUM_DATA_BITS-1:1]};
                        par_acc_d = par_acc_q ^ rx_s;
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_d = '0;
                            state_d   = (PARITY_EN != 0) ? STATE_PARITY_BIT : STATE_STOP_BIT;
                        end else begin
                            bit_idx_d = bit_idx_q + BIT_W'(1);
                        end
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                STATE_PARITY_BIT: begin
                    if (tick_q == FULL_TICK) begin
                        tick_d    = '0;
                        par_bad_d = rx_s ^ parity_expected(par_acc_q, 1'(PARITY_ODD));
                        state_d   = STATE_STOP_BIT;
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                STATE_STOP_BIT: begin
                    if (tick_q == FULL_TICK) begin
                        tick_d     = '0;
                        stop_bad_d = ~rx_s;
                        finish_d   = 1'b1;
                        state_d    = STATE_IDLE;
                    end else begin
                        tick_d = tick_inc;
                    end
                end
                default: begin
                    state_d = STATE_IDLE;
                    tick_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    assign data        = data_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign parity_err  = flags_q.parity_err;
    assign framing_err = flags_q.framing_err;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8E1 receiver, table vectors, corner sequences
// and random frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int unsigned OS   = 16;
    localparam logic        PODD = 1'b0;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       er;
    } rec_t;

    typedef struct {
        bit         m;
        logic [7:0] d;
        bit         bad_par;
        bit         stop;
        logic [7:0] exp_d;
        bit         exp_pe;
        bit         exp_fe;
    } vec_t;

    logic       baud = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       rx_n, rx_e;
    logic [7:0] data_n, data_e;
    logic       done_n, done_e, busy_n, busy_e;
    logic       error_n, error_e, pe_n, pe_e, fe_n, fe_e;

    int checks = 0;
    int errors = 0;

    rec_t q_n[$];
    rec_t q_e[$];
    int   busy_tot_n = 0;
    int   busy_tot_e = 0;
    int   mon_bad = 0;
    logic prev_done_n = 1'b0;
    logic prev_done_e = 1'b0;

    always #5 baud = ~baud;

    uart_rx #(.NUM_DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut_n (
        .baud(baud), .rst_n(rst_n), .enable(enable), .rx(rx_n),
        .data(data_n), .done(done_n), .busy(busy_n), .error(error_n),
        .parity_err(pe_n), .framing_err(fe_n)
    );

    uart_rx #(.NUM_DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .baud(baud), .rst_n(rst_n), .enable(enable), .rx(rx_e),
        .data(data_e), .done(done_e), .busy(busy_e), .error(error_e),
        .parity_err(pe_e), .framing_err(fe_e)
    );

    // Frame monitor: records every done, counts busy cycles, flags wide or overlapping done.
    always @(negedge baud) begin
        if (done_n) begin
            q_n.push_back({data_n, pe_n, fe_n, error_n});
            if (busy_n || prev_done_n) mon_bad++;
        end
        if (done_e) begin
            q_e.push_back({data_e, pe_e, fe_e, error_e});
            if (busy_e || prev_done_e) mon_bad++;
        end
        if (busy_n) busy_tot_n++;
        if (busy_e) busy_tot_e++;
        prev_done_n = done_n;
        prev_done_e = done_e;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge baud);
    endtask

    task automatic drive(input bit m, input logic v);
        if (m) rx_e = v;
        else   rx_n = v;
    endtask

    task automatic send_bit(input bit m, input logic v);
        drive(m, v);
        idle(OS);
    endtask

    // One frame, LSB first; the parity bit is only sent on the 8E1 line.
    task automatic send_frame(input bit m, input logic [7:0] d, input logic par, input logic stop);
        send_bit(m, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(m, d[i]);
        if (m) send_bit(m, par);
        send_bit(m, stop);
        drive(m, 1'b1);
    endtask

    // Reference: what the receiver must report for a frame with these line bits.
    function automatic rec_t model(input bit m, input logic [7:0] d, input logic par, input logic stop);
        rec_t r;
        r.d  = d;
        r.pe = m ? (par != ((^d) ^ PODD)) : 1'b0;
        r.fe = !stop;
        r.er = r.pe | r.fe;
        return r;
    endfunction

    function automatic int qsize(input bit m);
        return m ? q_e.size() : q_n.size();
    endfunction

    function automatic rec_t qget(input bit m, input int i);
        return m ? q_e[i] : q_n[i];
    endfunction

    function automatic int busy_tot(input bit m);
        return m ? busy_tot_e : busy_tot_n;
    endfunction

    initial begin
        vec_t       vt[8];
        rec_t       exp_n[$];
        rec_t       exp_e[$];
        rec_t       got;
        logic [7:0] d3c;
        int         n0, b0, nb, eb;

        vt[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vt[2] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0};
        vt[3] = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        vt[6] = '{1'b1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1};
        vt[7] = '{1'b0, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        d3c = 8'h3C;

        rst_n  = 1'b0;
        enable = 1'b1;
        rx_n   = 1'b1;
        rx_e   = 1'b1;
        idle(3);
        chk("rst_data", 32'(data_e), 32'h0);
        chk("rst_done", 32'(done_e), 32'h0);
        chk("rst_busy", 32'(busy_e), 32'h0);
        chk("rst_error", 32'(error_e), 32'h0);
        chk("rst_parity_err", 32'(pe_e), 32'h0);
        chk("rst_framing_err", 32'(fe_e), 32'h0);
        chk("rst_8n1_outputs", 32'({data_n, done_n, busy_n, error_n, pe_n, fe_n}), 32'h0);
        rst_n = 1'b1;
        idle(500);
        chk("idle_no_done_8n1", 32'(qsize(0)), 32'h0);
        chk("idle_no_done_8e1", 32'(qsize(1)), 32'h0);
        chk("idle_busy", 32'({busy_n, busy_e}), 32'h0);

        for (int i = 0; i < 8; i++) begin
            n0 = qsize(vt[i].m);
            b0 = busy_tot(vt[i].m);
            send_frame(vt[i].m, vt[i].d, (^vt[i].d) ^ vt[i].bad_par, vt[i].stop);
            idle(24);
            chk($sformatf("vec%0d_done_count", i), 32'(qsize(vt[i].m) - n0), 32'd1);
            if (qsize(vt[i].m) > n0) begin
                got = qget(vt[i].m, n0);
                chk($sformatf("vec%0d_data", i), 32'(got.d), 32'(vt[i].exp_d));
                chk($sformatf("vec%0d_parity_err", i), 32'(got.pe), 32'(vt[i].exp_pe));
                chk($sformatf("vec%0d_framing_err", i), 32'(got.fe), 32'(vt[i].exp_fe));
                chk($sformatf("vec%0d_error", i), 32'(got.er), 32'(vt[i].exp_pe | vt[i].exp_fe));
            end
            if (vt[i].m) chk_range($sformatf("vec%0d_busy_len", i), busy_tot(1) - b0, 168, 170);
            else         chk_range($sformatf("vec%0d_busy_len", i), busy_tot(0) - b0, 152, 154);
        end

        // Glitch on the 8N1 line: a short low pulse is a false start.
        n0 = qsize(0);
        b0 = busy_tot(0);
        rx_n = 1'b0;
        idle(4);
        rx_n = 1'b1;
        idle(30);
        chk_range("glitch_busy_len", busy_tot(0) - b0, 1, 9);
        chk("glitch_busy_low", 32'(busy_n), 32'h0);
        chk("glitch_no_done", 32'(qsize(0) - n0), 32'h0);

        // Enable dropped after the third data bit of 0x3C on the 8E1 line.
        n0 = qsize(1);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, d3c[i]);
        chk("en_busy_before", 32'(busy_e), 32'h1);
        enable = 1'b0;
        idle(1);
        chk("en_busy_after", 32'(busy_e), 32'h0);
        for (int i = 3; i < 8; i++) send_bit(1'b1, d3c[i]);
        send_bit(1'b1, ^d3c);
        send_bit(1'b1, 1'b1);
        idle(20);
        chk("en_no_done", 32'(qsize(1) - n0), 32'h0);
        chk("en_data_held", 32'(data_e), 32'h80);
        chk("en_flags_held", 32'({pe_e, fe_e, error_e}), 32'h7);
        enable = 1'b1;
        idle(5);
        n0 = qsize(1);
        send_frame(1'b1, d3c, ^d3c, 1'b1);
        idle(24);
        chk("reen_done_count", 32'(qsize(1) - n0), 32'd1);
        chk("reen_data", 32'(data_e), 32'h3C);
        chk("reen_error", 32'(error_e), 32'h0);

        // Reset mid-frame, then a line held low across reset must not start a frame.
        n0 = qsize(1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        chk("rstmid_busy_before", 32'(busy_e), 32'h1);
        rst_n = 1'b0;
        rx_e  = 1'b0;
        #1;
        chk("rstmid_busy", 32'(busy_e), 32'h0);
        chk("rstmid_data", 32'(data_e), 32'h0);
        chk("rstmid_flags", 32'({done_e, error_e, pe_e, fe_e}), 32'h0);
        idle(3);
        rst_n = 1'b1;
        idle(50);
        chk("low_line_no_start", 32'(busy_e), 32'h0);
        chk("low_line_no_done", 32'(qsize(1) - n0), 32'h0);
        rx_e = 1'b1;
        idle(10);

        // Back-to-back 8N1 frames with no idle gap.
        n0 = qsize(0);
        send_frame(1'b0, 8'h00, 1'b0, 1'b1);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b1);
        idle(24);
        chk("b2b_done_count", 32'(qsize(0) - n0), 32'd2);
        if (qsize(0) >= n0 + 2) begin
            chk("b2b_first", 32'(qget(0, n0)), 32'({8'h00, 3'b000}));
            chk("b2b_second", 32'(qget(0, n0 + 1)), 32'({8'hFF, 3'b000}));
        end

        // Random frames on both receivers against the reference model.
        nb = qsize(0);
        eb = qsize(1);
        for (int r = 0; r < 24; r++) begin
            bit         m;
            bit         bp;
            logic [7:0] d;
            logic       par, stop;
            m    = 1'($urandom_range(0, 1));
            d    = 8'($urandom);
            bp   = m && ($urandom_range(0, 3) == 0);
            par  = (^d) ^ bp;
            stop = ($urandom_range(0, 3) != 0);
            if (m) exp_e.push_back(model(m, d, par, stop));
            else   exp_n.push_back(model(m, d, par, stop));
            send_frame(m, d, par, stop);
            idle(stop ? $urandom_range(0, 3) : $urandom_range(2, 5));
        end
        idle(30);
        chk("rand_8n1_count", 32'(q_n.size() - nb), 32'(exp_n.size()));
        chk("rand_8e1_count", 32'(q_e.size() - eb), 32'(exp_e.size()));
        foreach (exp_n[i]) begin
            if (nb + i < q_n.size())
                chk($sformatf("rand_8n1_frame%0d", i), 32'(q_n[nb + i]), 32'(exp_n[i]));
        end
        foreach (exp_e[i]) begin
            if (eb + i < q_e.size())
                chk($sformatf("rand_8e1_frame%0d", i), 32'(q_e[eb + i]), 32'(exp_e[i]));
        end

        chk("done_width_busy_overlap", 32'(mon_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
